fp_operand_entry: RTL and testbench

Operand-entry stage directly upstream of the floating-point adder in the board test design. It captures two operands from the slide switches on successive debounced presses of a load button. It holds the operands in registers and drives the adder operand inputs (sign, 4-bit exponent, 8-bit fraction with explicit leading one). A valid flag asserts once both operands are loaded, so the adder result is displayed only for a complete, stable operand pair.

---
 rtl/fp_operand_entry.sv | 154 +++++++++++++++
 tb/tb_fp_operand_entry.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_entry.sv
`default_nettype none
// ==== fp_operand_entry : debounced two-operand capture feeding the FP adder ====
// ==== rev 1.0                                                                ====
module fp_operand_entry #(
  parameter int DB_CYCLES = 20'd1000000,
  parameter int CW        = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sw,
  input  logic        btn_load,
  input  logic        btn_clr,
  output logic        sign1,
  output logic [3:0]  exp1,
  output logic [7:0]  frac1,
  output logic        sign2,
  output logic [3:0]  exp2,
  output logic [7:0]  frac2,
  output logic        op_valid,
  output logic [1:0]  state_led
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HAVE1 = 2'b01,
    READY = 2'b10
  } state_t;

  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [1:0] btn_raw;
  logic [1:0] rise_p;
  logic       load_p;
  logic       clr_p;

  assign btn_raw = {btn_clr, btn_load};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic          db_prev_q, db_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronized level disagrees with the debounced one.
    always_comb begin
      sync1_d   = btn_raw[i];
      sync2_d   = sync1_q;
      db_prev_d = db_q;
      db_d      = db_q;
      cnt_d     = '0;
      if (sync2_q != db_q) begin
        if (cnt_q == DB_LAST) begin
          db_d = sync2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        db_q      <= db_d;
        db_prev_q <= db_prev_d;
        cnt_q     <= cnt_d;
      end
    end

    assign rise_p[i] = db_q & ~db_prev_q;
  end

  assign load_p = rise_p[0];
  assign clr_p  = rise_p[1];

  state_t      state_q, state_d;
  logic [12:0] op1_q, op1_d;
  logic [12:0] op2_q, op2_d;
  logic        op_valid_q, op_valid_d;
  logic [12:0] captured;
  logic        unused_sw;

  assign unused_sw = ^sw[2:0];

  // Operand packing is {sign, exp[3:0], frac[7:0]}; zero flag keeps only the sign.
  always_comb begin
    if (sw[3]) begin
      captured = {sw[15], 12'h000};
    end else begin
      captured = {sw[15], sw[14:11], 1'b1, sw[10:4]};
    end
  end

  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    op_valid_d = (state_q == READY);
    if (clr_p) begin
      state_d = EMPTY;
      op1_d   = '0;
      op2_d   = '0;
    end else if (load_p) begin
      case (state_q)
        EMPTY: begin
          op1_d   = captured;
          state_d = HAVE1;
        end
        HAVE1: begin
          op2_d   = captured;
          state_d = READY;
        end
        READY: begin
          op1_d   = captured;
          op2_d   = '0;
          state_d = HAVE1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      op1_q      <= '0;
      op2_q      <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign sign1     = op1_q[12];
  assign exp1      = op1_q[11:8];
  assign frac1     = op1_q[7:0];
  assign sign2     = op2_q[12];
  assign exp2      = op2_q[11:8];
  assign frac2     = op2_q[7:0];
  assign op_valid  = op_valid_q;
  assign state_led = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_operand_entry.sv
`default_nettype none
// ==== tb_fp_operand_entry : scoreboard bench for fp_operand_entry, rev 1.0 ====
module tb_fp_operand_entry;

  localparam int DB = 4;

  logic        clk;
  logic        reset;
  logic [15:0] sw;
  logic        btn_load;
  logic        btn_clr;
  logic        sign1, sign2, op_valid;
  logic [3:0]  exp1, exp2;
  logic [7:0]  frac1, frac2;
  logic [1:0]  state_led;

  fp_operand_entry #(.DB_CYCLES(DB), .CW(3)) dut (
    .clk(clk), .reset(reset), .sw(sw), .btn_load(btn_load), .btn_clr(btn_clr),
    .sign1(sign1), .exp1(exp1), .frac1(frac1),
    .sign2(sign2), .exp2(exp2), .frac2(frac2),
    .op_valid(op_valid), .state_led(state_led)
  );

  typedef struct {
    logic [12:0] op1;
    logic [12:0] op2;
    logic [1:0]  st;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        ld;
    logic        cl;
    logic [15:0] sw;
    logic [12:0] op1;
    logic [12:0] op2;
    logic [1:0]  st;
    logic        valid;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[9];
  int          tests  = 0;
  int          failed = 0;
  int          cyc    = 0;
  logic [27:0] cur;
  logic [27:0] last = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Every change of operands/state while out of reset must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    cur = {sign1, exp1, frac1, sign2, exp2, frac2, state_led};
    if (reset && cur !== last) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_change: got %0h expected %0h (cycle %0d)", cur, last, cyc);
      end else begin
        e = sb.pop_front();
        check("op1", 32'(cur[27:15]), 32'(e.op1));
        check("op2", 32'(cur[14:2]), 32'(e.op2));
        check("state_led", 32'(cur[1:0]), 32'(e.st));
        check("capture_cycle", cyc, e.cyc);
      end
    end
    last = cur;
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL capture_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic release_btns();
    btn_load = 1'b0;
    btn_clr  = 1'b0;
    repeat (DB + 8) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic ld, input logic cl, input logic [15:0] s,
                       input logic [12:0] o1, input logic [12:0] o2, input logic [1:0] st);
    exp_t e;
    sw = s;
    @(posedge clk);
    #1;
    btn_load = ld;
    btn_clr  = cl;
    e.op1 = o1;
    e.op2 = o2;
    e.st  = st;
    e.cyc = cyc + DB + 3;
    sb.push_back(e);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 16'h1230, {1'b0, 4'h2, 8'hA3}, 13'h0, 2'b01, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h9AB0, {1'b0, 4'h2, 8'hA3}, {1'b1, 4'h3, 8'hAB}, 2'b10, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 16'h0800, {1'b0, 4'h1, 8'h80}, 13'h0, 2'b01, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h7FF8, {1'b0, 4'h1, 8'h80}, 13'h0, 2'b10, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 16'hFFF8, {1'b1, 4'h0, 8'h00}, 13'h0, 2'b01, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'h1230, 13'h0, 13'h0, 2'b00, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'h7FF8, 13'h0, 13'h0, 2'b01, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 16'h4A50, 13'h0, {1'b0, 4'h9, 8'hA5}, 2'b10, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 16'h0000, 13'h0, 13'h0, 2'b00, 1'b0};

    reset    = 1'b0;
    sw       = 16'h0000;
    btn_load = 1'b0;
    btn_clr  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(state_led), 32'd0);
    check("reset_ops", 32'({sign1, exp1, frac1, sign2, exp2, frac2}), 32'd0);
    check("reset_valid", 32'(op_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("idle_state", 32'(state_led), 32'd0);

    for (int i = 0; i < 9; i++) begin
      press(vecs[i].ld, vecs[i].cl, vecs[i].sw, vecs[i].op1, vecs[i].op2, vecs[i].st);
      check("op_valid", 32'(op_valid), 32'(vecs[i].valid));
      release_btns();
    end

    // Bounce: 2-clock toggles never settle; only the final steady press loads.
    begin
      exp_t e;
      sw = 16'h3C70;
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) begin
        btn_load = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        btn_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      btn_load = 1'b1;
      e.op1 = {1'b0, 4'h7, 8'hC7};
      e.op2 = 13'h0;
      e.st  = 2'b01;
      e.cyc = cyc + DB + 3;
      sb.push_back(e);
      drain();
      repeat (30) @(posedge clk);
      #1;
      check("bounce_valid", 32'(op_valid), 32'd0);
      release_btns();
    end

    // Simultaneous load and clear from HAVE1: clear wins.
    press(1'b1, 1'b1, 16'h9AB0, 13'h0, 13'h0, 2'b00);
    check("clr_prio_valid", 32'(op_valid), 32'd0);
    release_btns();

    // Async reset from READY while a load is mid-debounce.
    press(1'b1, 1'b0, 16'h1230, {1'b0, 4'h2, 8'hA3}, 13'h0, 2'b01);
    release_btns();
    press(1'b1, 1'b0, 16'h9AB0, {1'b0, 4'h2, 8'hA3}, {1'b1, 4'h3, 8'hAB}, 2'b10);
    release_btns();
    check("ready_valid", 32'(op_valid), 32'd1);
    sw = 16'h0800;
    @(posedge clk);
    #1;
    btn_load = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_state", 32'(state_led), 32'd0);
    check("async_ops", 32'({sign1, exp1, frac1, sign2, exp2, frac2}), 32'd0);
    check("async_valid", 32'(op_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    begin
      exp_t e;
      e.op1 = {1'b0, 4'h1, 8'h80};
      e.op2 = 13'h0;
      e.st  = 2'b01;
      e.cyc = cyc + DB + 3;
      sb.push_back(e);
    end
    drain();
    check("post_reset_valid", 32'(op_valid), 32'd0);
    repeat (20) @(posedge clk);
    release_btns();
    check("final_state", 32'(state_led), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
